icache_r32i: RTL and testbench
==============================

Name: icache_r32i

Overview:
Direct-mapped, read-only instruction cache that sits between the RISCV32I PC and the instruction memory. It takes the PC's program address and returns the 32-bit instruction word. On a miss it asserts InsCacheStall to freeze the PC while it refills the line from memory, word by word, over a request/valid handshake.

Parameters:
dataW, 32, address and instruction width
LINES, 16, number of cache lines (power of 2, at least 2)
WORDS, 4, 32-bit words per line (power of 2, at least 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
ProgAddr  in  dataW  fetch address from the PC
Flush  in  1  invalidate all lines (e.g. fence.i)
Instruction  out  32  instruction word for ProgAddr; 32'h00000013 (NOP) while stalled
InsCacheStall  out  1  high while the fetch cannot be served this cycle
MemReq  out  1  refill word request
MemAddr  out  dataW  word-aligned refill address
MemValid  in  1  MemData valid; accepts the current request
MemData  in  32  refill data

Behaviour:
- Reset: asynchronous, active-high, using clock as the clock. All valid bits clear, FSM to IDLE, word counter 0, MemReq 0, MemAddr 0, flush-pending 0. Once reset releases, every lookup misses, so InsCacheStall=1 and Instruction=NOP.
- Address split: [1:0] ignored (fetches are word-aligned); next log2(WORDS) bits = word select; next log2(LINES) bits = index; the remaining upper bits = tag.
- Lookup is combinational on ProgAddr. hit = valid[index] && tag match && state==IDLE.
  - InsCacheStall = !hit.
  - Instruction = data[index][word] on a hit, otherwise NOP.
- FSM states: IDLE and FILL.
  - IDLE, miss, Flush low: latch the line base address (ProgAddr with word-select and byte bits zeroed), set counter=0, go to FILL at the next edge.
  - FILL: MemReq=1 and MemAddr = base + 4*counter. In each cycle where MemValid=1, write MemData to data[idx][counter] and increment counter. MemValid=0 holds all state (any number of wait states).
  - At the edge that accepts word WORDS-1: write the tag, set valid[idx]=1, go to IDLE. MemReq is low in the following cycle.
- Miss penalty with zero-wait memory: 1 detect cycle + WORDS fill cycles. The default configuration stalls for 5 cycles, and the hit appears in the 6th.
- The line becomes valid only after all words are written. A partial line is never hit.
- ProgAddr changing during FILL has no effect on the fill. The address latched at the miss is used, and lookup resumes in IDLE with the current ProgAddr.
- Flush:
  - In IDLE: clears all valid bits at the edge, and InsCacheStall=1 in that cycle. Flush has priority over starting a fill.
  - In FILL: sets flush-pending. The fill completes but its line is not validated, all valid bits are cleared on return to IDLE, and flush-pending clears.
- Reset during FILL aborts immediately: MemReq=0, all lines invalid, IDLE.
- Counter width is log2(WORDS). It wraps to 0 after the last word, with no overflow state.
- Tag and data arrays are not reset. Only the valid bits are reset.

Test Plan:
- Cold miss: release reset, ProgAddr=0x00000000, memory returns 0x11111111..0x44444444 with MemValid always 1 -> MemAddr 0x0,0x4,0x8,0xC in cycles 1-4; stall high in cycles 0-4; in cycle 5 stall=0 and Instruction=0x11111111.
- Hits within line: after the fill, ProgAddr=0x8 then 0xC -> stall=0 in both cycles, Instruction=0x33333333 then 0x44444444, MemReq=0.
- Wait states: miss at 0x40, MemValid high only every third cycle -> MemAddr advances only on accepted words; stall is held through 1+12 cycles; the line at index 4 is then valid.
- Conflict eviction: fill 0x000, then miss at 0x100 (same index 0, tag 1) with new data -> refill; ProgAddr=0x000 then misses again.
- Flush: Flush pulse during FILL of 0x200 -> the fill completes (4 MemReq beats); afterwards 0x200 and the earlier-cached 0x0 both miss.
- Reset mid-fill: assert reset after 2 accepted words -> MemReq drops asynchronously; after release, the same address misses and refetches from word 0.

Source files
------------

// File: rtl/icache_r32i.sv
// icache_r32i -- direct-mapped, read-only instruction cache for the RV32I fetch path.
//
// Lookup is combinational on ProgAddr. On a miss the cache stalls the PC and
// refills the whole line from instruction memory, one word per accepted
// MemReq/MemValid handshake. Only the valid bits are reset; tag and data
// arrays come up undefined and are never read while their line is invalid.
//
// Ports
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   ProgAddr        fetch address from the PC (bits [1:0] ignored)
//   Flush           invalidate every line (fence.i)
//   Instruction     instruction word on a hit, NOP otherwise
//   InsCacheStall   high whenever the fetch cannot be served this cycle
//   MemReq/MemAddr  refill word request and its word-aligned address
//   MemValid        MemData is valid and the current request is accepted
//   MemData         refill data
//
// FSM states
//   state | meaning
//   IDLE  | serving lookups; a miss latches the line address and starts a refill
//   FILL  | requesting line words in order; line validated after the last word

module icache_r32i #(
    parameter int dataW = 32,
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    output logic [31:0]      Instruction,
    output logic             InsCacheStall,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    input  logic             MemValid,
    input  logic [31:0]      MemData
);

    localparam int WSEL = $clog2(WORDS);
    localparam int ISEL = $clog2(LINES);
    // line address = tag + index, i.e. ProgAddr without word-select and byte bits
    localparam int LBW  = dataW - 2 - WSEL;
    localparam int TAGW = LBW - ISEL;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {IDLE, FILL} stateT;

    stateT            state;
    logic [LINES-1:0] validBits;
    logic [LBW-1:0]   fillLine;
    logic [WSEL-1:0]  wordCnt;
    logic             flushPending;

    logic [TAGW-1:0]  tagArray  [LINES];
    logic [31:0]      dataArray [LINES*WORDS];

    logic [WSEL-1:0]  reqWord;
    logic [ISEL-1:0]  reqIndex;
    logic [TAGW-1:0]  reqTag;
    logic [ISEL-1:0]  fillIndex;
    logic [TAGW-1:0]  fillTag;
    logic             lastWord;
    logic             lookupHit;
    logic             hit;
    logic             unusedByteBits;

    assign reqWord   = ProgAddr[2 +: WSEL];
    assign reqIndex  = ProgAddr[2+WSEL +: ISEL];
    assign reqTag    = ProgAddr[dataW-1 -: TAGW];
    assign fillIndex = fillLine[ISEL-1:0];
    assign fillTag   = fillLine[LBW-1 -: TAGW];
    assign lastWord  = (wordCnt == WSEL'(WORDS-1));

    // Fetches are word-aligned, so the byte offset never participates.
    assign unusedByteBits = ^ProgAddr[1:0];

    // lookupHit decides whether a fill starts; hit additionally masks the
    // cycle in which a flush is being applied so stale data is never served.
    assign lookupHit = validBits[reqIndex] && (tagArray[reqIndex] == reqTag) && (state == IDLE);
    assign hit       = lookupHit && !Flush;

    assign InsCacheStall = !hit;
    assign Instruction   = hit ? dataArray[{reqIndex, reqWord}] : NOP;

    // Built from registers only, so it is stable for the whole request cycle.
    assign MemAddr = {fillLine, wordCnt, 2'b00};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            validBits    <= '0;
            fillLine     <= '0;
            wordCnt      <= '0;
            flushPending <= 1'b0;
            MemReq       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush) begin
                        validBits <= '0;
                    end else if (!lookupHit) begin
                        fillLine <= ProgAddr[dataW-1 : 2+WSEL];
                        wordCnt  <= '0;
                        MemReq   <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (Flush) begin
                        flushPending <= 1'b1;
                    end
                    if (MemValid) begin
                        wordCnt <= wordCnt + 1'b1;
                        if (lastWord) begin
                            state        <= IDLE;
                            MemReq       <= 1'b0;
                            flushPending <= 1'b0;
                            // A flush seen at any point during the fill (including
                            // this last cycle) discards the line just fetched.
                            if (flushPending || Flush) begin
                                validBits <= '0;
                            end else begin
                                validBits[fillIndex] <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Storage arrays: no reset, written only while filling.
    always_ff @(posedge clock) begin
        if (state == FILL && MemValid) begin
            dataArray[{fillIndex, wordCnt}] <= MemData;
            if (lastWord) begin
                tagArray[fillIndex] <= fillTag;
            end
        end
    end

endmodule

// File: tb/tb_icache_r32i.sv
module tb_icache_r32i;

    localparam int WORDS = 4;
    localparam int LINES = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ProgAddr;
    logic        Flush;
    logic [31:0] Instruction;
    logic        InsCacheStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemValid;
    logic [31:0] MemData;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    icache_r32i dut (
        .clock(clock),
        .reset(reset),
        .ProgAddr(ProgAddr),
        .Flush(Flush),
        .Instruction(Instruction),
        .InsCacheStall(InsCacheStall),
        .MemReq(MemReq),
        .MemAddr(MemAddr),
        .MemValid(MemValid),
        .MemData(MemData)
    );

    // ---------------- reference model: set of cached line addresses ----------
    bit          mValid [LINES];
    logic [31:0] mLine  [LINES];
    bit          mFill;
    logic [31:0] mBase;
    int          mBeats;
    bit          mPf;
    int          fillCyc;
    int          vmode;     // 0: zero-wait, 1: every third fill cycle, 2: random

    // Instruction memory contents: fixed for the whole run.
    function automatic logic [31:0] memVal(input logic [31:0] a);
        if (a < 32'h10) return 32'h11111111 * ((a >> 2) + 1);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [31:0] lineOf(input logic [31:0] a);
        return a & ~32'(WORDS*4-1);
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / (WORDS*4)) % LINES);
    endfunction

    function automatic bit lookup(input logic [31:0] a);
        return mValid[idxOf(a)] && (mLine[idxOf(a)] == lineOf(a));
    endfunction

    task automatic clearAll();
        for (int i = 0; i < LINES; i++) mValid[i] = 0;
    endtask

    task automatic modelReset();
        clearAll();
        mFill = 0; mBeats = 0; mPf = 0; fillCyc = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyInputs(input logic [31:0] addr, input logic fl);
        @(negedge clock);
        ProgAddr = addr;
        Flush    = fl;
        if (mFill) begin
            case (vmode)
                0:       MemValid = 1'b1;
                1:       MemValid = (fillCyc % 3 == 2);
                default: MemValid = ($urandom_range(0, 1) == 1);
            endcase
            MemData = memVal(mBase + 32'(4 * mBeats));
        end else begin
            MemValid = ($urandom_range(0, 3) == 0);
            MemData  = $urandom;
        end
        #1;
    endtask

    task automatic modelCheck();
        bit expHit;
        expHit = !mFill && !Flush && lookup(ProgAddr);
        check("stall", InsCacheStall, expHit ? 0 : 1);
        check("instruction", Instruction, expHit ? memVal({ProgAddr[31:2], 2'b00}) : NOP);
        check("memreq", MemReq, mFill ? 1 : 0);
        if (mFill) check("memaddr", MemAddr, mBase + 32'(4 * mBeats));
    endtask

    task automatic finishCycle();
        @(posedge clock);
        if (mFill) begin
            fillCyc++;
            if (Flush) mPf = 1;
            if (MemValid) begin
                mBeats++;
                if (mBeats == WORDS) begin
                    mFill = 0;
                    if (mPf) clearAll();
                    else begin
                        mValid[idxOf(mBase)] = 1;
                        mLine[idxOf(mBase)]  = mBase;
                    end
                    mPf = 0;
                end
            end
        end else if (Flush) begin
            clearAll();
        end else if (!lookup(ProgAddr)) begin
            mFill = 1; mBase = lineOf(ProgAddr); mBeats = 0; fillCyc = 0;
        end
    endtask

    task automatic cycle(input logic [31:0] addr, input logic fl);
        applyInputs(addr, fl);
        modelCheck();
        finishCycle();
    endtask

    // Present addr until it hits (or until a full line is transferred when
    // stopOnFill is set); report stall cycles, accepted beats, first MemAddr.
    task automatic runMiss(input logic [31:0] addr, input int flushAt, input bit stopOnFill,
                           input int budget, output int stalls, output int beats,
                           output logic [31:0] firstAddr);
        bit done = 0;
        bit hitSeen;
        bit gotAddr = 0;
        stalls = 0; beats = 0; firstAddr = '0;
        for (int i = 0; i < budget && !done; i++) begin
            applyInputs(addr, (i == flushAt));
            modelCheck();
            if (InsCacheStall) stalls++;
            if (MemReq && !gotAddr) begin firstAddr = MemAddr; gotAddr = 1; end
            if (MemReq && MemValid) beats++;
            hitSeen = !InsCacheStall;
            finishCycle();
            if (hitSeen || (stopOnFill && beats == WORDS)) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout at addr %h: no completion within %0d cycles", addr, budget);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        expStall;
        logic        expReq;
        logic [31:0] expMemAddr;
        logic [31:0] expInstr;
    } vecT;

    vecT vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stalls, beats;
        logic [31:0] firstAddr;
        logic [31:0] a;

        // cold miss at 0x0 followed by in-line hits, zero-wait memory
        vecs[0] = '{32'h0, 1, 0, 32'h0, NOP};
        vecs[1] = '{32'h0, 1, 1, 32'h0, NOP};
        vecs[2] = '{32'h0, 1, 1, 32'h4, NOP};
        vecs[3] = '{32'h0, 1, 1, 32'h8, NOP};
        vecs[4] = '{32'h0, 1, 1, 32'hC, NOP};
        vecs[5] = '{32'h0, 0, 0, 32'h0, 32'h11111111};
        vecs[6] = '{32'h8, 0, 0, 32'h0, 32'h33333333};
        vecs[7] = '{32'hC, 0, 0, 32'h0, 32'h44444444};

        reset = 1; ProgAddr = 0; Flush = 0; MemValid = 0; MemData = 0;
        vmode = 0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_stall", InsCacheStall, 1);
        check("reset_memreq", MemReq, 0);
        check("reset_memaddr", MemAddr, 0);
        check("reset_instr", Instruction, NOP);
        reset = 0;

        for (int i = 0; i < 8; i++) begin
            applyInputs(vecs[i].addr, 0);
            modelCheck();
            check($sformatf("vec%0d_stall", i), InsCacheStall, vecs[i].expStall);
            check($sformatf("vec%0d_memreq", i), MemReq, vecs[i].expReq);
            if (vecs[i].expReq) check($sformatf("vec%0d_memaddr", i), MemAddr, vecs[i].expMemAddr);
            check($sformatf("vec%0d_instr", i), Instruction, vecs[i].expInstr);
            finishCycle();
        end

        // wait states: one accepted word every third fill cycle
        vmode = 1;
        runMiss(32'h40, -1, 0, 100, stalls, beats, firstAddr);
        check("wait_stalls", stalls, 13);
        check("wait_first_addr", firstAddr, 32'h40);
        vmode = 0;
        applyInputs(32'h4C, 0);
        modelCheck();
        check("wait_line4_hit", InsCacheStall, 0);
        finishCycle();

        // conflict eviction at index 0
        runMiss(32'h100, -1, 0, 50, stalls, beats, firstAddr);
        check("conflict_stalls", stalls, 5);
        runMiss(32'h0, -1, 0, 50, stalls, beats, firstAddr);
        check("evicted_refetch_stalls", stalls, 5);

        // flush in IDLE stalls that cycle and invalidates the cached line
        applyInputs(32'h0, 1);
        modelCheck();
        check("idle_flush_stall", InsCacheStall, 1);
        finishCycle();
        runMiss(32'h0, -1, 0, 50, stalls, beats, firstAddr);
        check("after_idle_flush_stalls", stalls, 5);

        // flush during a fill: fill completes but nothing stays valid
        runMiss(32'h200, 2, 1, 50, stalls, beats, firstAddr);
        check("flush_fill_beats", beats, 4);
        runMiss(32'h0, -1, 0, 50, stalls, beats, firstAddr);
        check("flush_old_line_stalls", stalls, 5);
        runMiss(32'h200, -1, 0, 50, stalls, beats, firstAddr);
        check("flush_fill_line_stalls", stalls, 5);

        // reset after two accepted words aborts the fill
        cycle(32'h300, 0);
        cycle(32'h300, 0);
        cycle(32'h300, 0);
        @(negedge clock);
        #2 reset = 1;
        #1;
        check("midreset_memreq", MemReq, 0);
        check("midreset_stall", InsCacheStall, 1);
        modelReset();
        @(posedge clock);
        #1 reset = 0;
        runMiss(32'h300, -1, 0, 50, stalls, beats, firstAddr);
        check("midreset_refetch_addr", firstAddr, 32'h300);
        check("midreset_refetch_stalls", stalls, 5);

        // random traffic against the model
        vmode = 2;
        a = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 31)) << 2);
            cycle(a, ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
